player_session_ctrl: RTL
========================

# player_session_ctrl

Front-end session controller that drives the BCD math game core from the board's user controls. It turns debounced button pulses and switch values into the core's control strobes: `Logged_In`, `Game_Start`, `Load_Input`, `Timeout`, `playerID` and `Player_Input`. It owns the round timer and waits for the core's scoring completion. It sits between the button/switch conditioning logic and the game core, and is the initiator for the protocol the core responds to.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second of round time.
- `ROUND_SECONDS`, default 30: round length in seconds (1..63).
- `RESULT_HOLD`, default 3: seconds the result state is held before returning to READY.
- `SCORE_WAIT`, default 1024: maximum number of cycles spent waiting for `score_valid`.
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `btn_login` in 1: one-cycle pulse, already debounced.
- `btn_logout` in 1: one-cycle pulse.
- `btn_enter` in 1: one-cycle pulse; starts a round or submits a digit.
- `sw_id` in 5: player ID switches; ID 0 is reserved and invalid.
- `sw_digit` in 4: BCD digit switches.
- `score_valid` in 1: one-cycle pulse from the core when scoring of the round has finished.
- `Logged_In` out 1: a player is logged in.
- `Game_Start` out 1: one-cycle pulse that starts a round.
- `Load_Input` out 1: one-cycle pulse; `Player_Input` is valid in the same cycle.
- `Timeout` out 1: one-cycle pulse at round expiry.
- `playerID` out 5: latched ID of the logged-in player.
- `Player_Input` out 4: last accepted BCD digit.
- `secs_left` out 6: remaining round seconds, for display.
- `bad_digit` out 1: one-cycle pulse when an enter is rejected because the digit is greater than 9.
- `state_code` out 3: encoded current state, for the LED/debug display.

## Operation
States: IDLE=0, READY=1, START=2, PLAY=3, SCORE=4, RESULT=5.
- IDLE
  - `btn_login` with `sw_id`≠0: latch `playerID`, set `Logged_In`=1, go to READY.
  - `btn_login` with `sw_id`=0: ignored.
- READY
  - `btn_enter`: go to START.
  - `btn_logout`: go to IDLE; clear `Logged_In` and `playerID`.
- START (one cycle)
  - `Game_Start`=1; load `secs_left`=ROUND_SECONDS; clear the prescaler; go to PLAY.
- PLAY
  - `btn_enter` with `sw_digit`≤9: `Player_Input`←`sw_digit`, `Load_Input`=1 in the next cycle.
  - `btn_enter` with `sw_digit`>9: `bad_digit`=1 in the next cycle; `Player_Input` is unchanged.
  - Prescaler counts 0..TICKS_PER_SEC-1; on wrap, `secs_left` decrements.
  - When `secs_left` reaches 0: `Timeout`=1 for one cycle, then go to SCORE.
  - `btn_login` and `btn_logout` are ignored.
- SCORE
  - `score_valid`: go to RESULT.
  - After SCORE_WAIT cycles without `score_valid`: go to READY (watchdog).
  - Logout is ignored.
- RESULT
  - Hold for RESULT_HOLD seconds, reusing the prescaler, then go to READY.
  - `btn_logout` goes to IDLE immediately.
- Boundary conditions:
  - `btn_enter` in the same cycle as expiry: expiry wins; the digit is dropped and neither `Load_Input` nor `bad_digit` pulses.
  - `score_valid` outside SCORE: ignored.
  - `btn_enter` and `btn_logout` together in READY: logout wins.
  - `secs_left` saturates at 0 and never wraps.
- Reset (any state, including mid-round):
  - state IDLE;
  - all outputs 0;
  - `secs_left`=0;
  - prescaler and watchdog cleared.
  - No `Timeout` pulse is issued when reset aborts a round.

## Timing
- All outputs are registered.
- `Game_Start` is high exactly 2 cycles after the `btn_enter` pulse in READY: one cycle to enter START, one to register the pulse.
- `Load_Input` and `bad_digit` are high exactly 1 cycle after the accepted `btn_enter`.
- `Player_Input` is stable from the `Load_Input` cycle until the next accepted digit.
- `Timeout` is asserted in the cycle after the prescaler wrap that brings `secs_left` to 0.
  - Round length from the `Game_Start` cycle to the `Timeout` cycle is ROUND_SECONDS×TICKS_PER_SEC cycles.
- SCORE is entered in the cycle after `Timeout`.
- `Logged_In` rises 1 cycle after a valid `btn_login` and falls 1 cycle after an accepted `btn_logout`.
- Output pulse strobes never overlap: `Game_Start`, `Load_Input` and `Timeout` are mutually exclusive.

## Structure
- Shared `game_pkg` holds:
  - the state enum, whose encodings are exactly the `state_code` values;
  - `BCD_MAX`=9;
  - `ID_RESERVED`=0;
  - widths `ID_W`=5 and `DIGIT_W`=4.
- Sub-module `sec_timer`: prescaler plus 6-bit saturating down-counter.
  - Ports: `load`, `load_val`, `run`, `tick` (wrap pulse), `count`, `zero`.
  - It is used for both the round countdown and the RESULT hold.
- The SCORE watchdog is a separate counter in the top.

## Test plan
Benches use TICKS_PER_SEC=4, ROUND_SECONDS=3, RESULT_HOLD=2, SCORE_WAIT=16.
- Login rejection and acceptance:
  - `btn_login` with `sw_id`=0 → `Logged_In` stays 0 and `state_code`=0.
  - `sw_id`=5 → `Logged_In`=1, `playerID`=5, `state_code`=1.
- Start and digit entry:
  - `btn_enter` in READY → `Game_Start` one cycle, `secs_left`=3.
  - Enter `sw_digit`=7 → `Load_Input`=1 with `Player_Input`=7, one cycle after the enter.
  - Enter `sw_digit`=12 → `bad_digit` pulse; `Player_Input` stays 7.
- Round expiry: 12 cycles after `Game_Start` → one `Timeout` pulse, `secs_left`=0, `state_code`=4.
  - `btn_enter` in the expiry cycle → no `Load_Input`.
- Scoring paths:
  - `score_valid` 5 cycles into SCORE → RESULT; after 8 cycles → READY.
  - No `score_valid` → READY after 16 cycles.
- Logout rules:
  - `btn_logout` in PLAY → ignored.
  - `btn_logout` in RESULT → IDLE next cycle, `Logged_In`=0, `playerID`=0.
- Mid-round reset: assert `reset` in PLAY with `secs_left`=2 → all outputs 0 asynchronously, no `Timeout`, state IDLE after release.

Source files
------------

// File: rtl/player_session_ctrl_pkg.sv
// Shared types and constants for the game front-end: state encoding,
// field widths and the BCD range check used on the digit switches.
package game_pkg;

  localparam int ID_W    = 5;
  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX     = 4'd9;
  localparam logic [ID_W-1:0]    ID_RESERVED = 5'd0;

  // Encodings double as the state_code shown on the debug LEDs
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_START  = 3'd2,
    ST_PLAY   = 3'd3,
    ST_SCORE  = 3'd4,
    ST_RESULT = 3'd5
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/player_session_ctrl_if.sv
// User controls in, game-core control strobes and display values out.
// master = session controller, slave = button logic / game core side.
interface player_session_ctrl_if;
  import game_pkg::*;

  logic               btn_login;
  logic               btn_logout;
  logic               btn_enter;
  logic [ID_W-1:0]    sw_id;
  logic [DIGIT_W-1:0] sw_digit;
  logic               score_valid;

  logic               Logged_In;
  logic               Game_Start;
  logic               Load_Input;
  logic               Timeout;
  logic [ID_W-1:0]    playerID;
  logic [DIGIT_W-1:0] Player_Input;
  logic [5:0]         secs_left;
  logic               bad_digit;
  logic [2:0]         state_code;

  modport master (
    input  btn_login, btn_logout, btn_enter, sw_id, sw_digit, score_valid,
    output Logged_In, Game_Start, Load_Input, Timeout, playerID,
           Player_Input, secs_left, bad_digit, state_code
  );

  modport slave (
    output btn_login, btn_logout, btn_enter, sw_id, sw_digit, score_valid,
    input  Logged_In, Game_Start, Load_Input, Timeout, playerID,
           Player_Input, secs_left, bad_digit, state_code
  );

endinterface

// File: rtl/player_session_ctrl_sec_timer.sv
// Seconds timer: a prescaler dividing clk down to one tick per second and
// a 6-bit down-counter that decrements on each tick and sticks at zero.
module sec_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       run,
  output logic       tick,
  output logic [5:0] count,
  output logic       zero
);

  localparam int            PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] r_pre;
  logic [5:0]    r_count;

  assign tick  = run && (r_pre == PRE_MAX);
  assign count = r_count;
  assign zero  = (r_count == 6'd0);

  // Prescaler: restarts on load so every second is a full second
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_pre <= '0;
    else if (load)  r_pre <= '0;
    else if (tick)  r_pre <= '0;
    else if (run)   r_pre <= r_pre + 1'b1;
  end

  // Seconds counter: saturates at zero instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_count <= 6'd0;
    else if (load)                      r_count <= load_val;
    else if (tick && r_count != 6'd0)   r_count <= r_count - 6'd1;
  end

endmodule

// File: rtl/player_session_ctrl.sv
// Session controller: login/logout, round start, digit entry, round timer,
// scoring wait with watchdog and result hold. All outputs are registered.
module player_session_ctrl
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ROUND_SECONDS = 30,
  parameter int RESULT_HOLD   = 3,
  parameter int SCORE_WAIT    = 1024
) (
  input logic                  clk,
  input logic                  reset,
  player_session_ctrl_if.master bus
);

  localparam int            WW       = $clog2(SCORE_WAIT + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(SCORE_WAIT - 1);

  state_t             r_state, w_state_next;
  logic               r_logged_in, w_logged_in_next;
  logic [ID_W-1:0]    r_player_id, w_player_id_next;
  logic [DIGIT_W-1:0] r_player_input, w_player_input_next;
  logic               r_game_start, w_game_start_next;
  logic               r_load_input, w_load_input_next;
  logic               r_timeout, w_timeout_next;
  logic               r_bad_digit, w_bad_digit_next;
  logic [WW-1:0]      r_wdog;

  logic               w_tmr_load;
  logic [5:0]         w_tmr_val;
  logic               w_tmr_run;
  logic               w_tmr_tick;
  logic [5:0]         w_tmr_count;
  logic               w_tmr_zero;
  logic               w_last_tick;

  // One timer serves both the round countdown and the result hold
  sec_timer #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .run      (w_tmr_run),
    .tick     (w_tmr_tick),
    .count    (w_tmr_count),
    .zero     (w_tmr_zero)
  );

  // The tick that takes the counter from 1 to 0 ends the round / hold
  assign w_last_tick = w_tmr_tick && (w_tmr_count == 6'd1);
  assign w_tmr_run   = ((r_state == ST_PLAY) && !w_tmr_zero) || (r_state == ST_RESULT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_next        = r_state;
    w_logged_in_next    = r_logged_in;
    w_player_id_next    = r_player_id;
    w_player_input_next = r_player_input;
    w_game_start_next   = 1'b0;
    w_load_input_next   = 1'b0;
    w_timeout_next      = 1'b0;
    w_bad_digit_next    = 1'b0;
    w_tmr_load          = 1'b0;
    w_tmr_val           = 6'd0;

    case (r_state)
      ST_IDLE: begin
        if (bus.btn_login && bus.sw_id != ID_RESERVED) begin
          w_state_next     = ST_READY;
          w_logged_in_next = 1'b1;
          w_player_id_next = bus.sw_id;
        end
      end
      ST_READY: begin
        // Logout has priority over a simultaneous enter
        if (bus.btn_logout) begin
          w_state_next     = ST_IDLE;
          w_logged_in_next = 1'b0;
          w_player_id_next = '0;
        end else if (bus.btn_enter) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_game_start_next = 1'b1;
        w_tmr_load        = 1'b1;
        w_tmr_val         = 6'(ROUND_SECONDS);
        w_state_next      = ST_PLAY;
      end
      ST_PLAY: begin
        // Expiry (and the cycle after it) swallows any digit entry
        if (w_tmr_zero) begin
          w_state_next = ST_SCORE;
        end else if (w_last_tick) begin
          w_timeout_next = 1'b1;
        end else if (bus.btn_enter) begin
          if (is_bcd(bus.sw_digit)) begin
            w_player_input_next = bus.sw_digit;
            w_load_input_next   = 1'b1;
          end else begin
            w_bad_digit_next = 1'b1;
          end
        end
      end
      ST_SCORE: begin
        if (bus.score_valid) begin
          w_state_next = ST_RESULT;
          w_tmr_load   = 1'b1;
          w_tmr_val    = 6'(RESULT_HOLD);
        end else if (r_wdog == WDOG_MAX) begin
          w_state_next = ST_READY;
        end
      end
      ST_RESULT: begin
        if (bus.btn_logout) begin
          w_state_next     = ST_IDLE;
          w_logged_in_next = 1'b0;
          w_player_id_next = '0;
        end else if (w_last_tick) begin
          w_state_next = ST_READY;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_logged_in    <= 1'b0;
      r_player_id    <= '0;
      r_player_input <= '0;
      r_game_start   <= 1'b0;
      r_load_input   <= 1'b0;
      r_timeout      <= 1'b0;
      r_bad_digit    <= 1'b0;
    end else begin
      r_logged_in    <= w_logged_in_next;
      r_player_id    <= w_player_id_next;
      r_player_input <= w_player_input_next;
      r_game_start   <= w_game_start_next;
      r_load_input   <= w_load_input_next;
      r_timeout      <= w_timeout_next;
      r_bad_digit    <= w_bad_digit_next;
    end
  end

  // Scoring watchdog: counts cycles spent in SCORE, idle elsewhere
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_wdog <= '0;
    else if (r_state != ST_SCORE) r_wdog <= '0;
    else                          r_wdog <= r_wdog + 1'b1;
  end

  assign bus.Logged_In    = r_logged_in;
  assign bus.playerID     = r_player_id;
  assign bus.Player_Input = r_player_input;
  assign bus.Game_Start   = r_game_start;
  assign bus.Load_Input   = r_load_input;
  assign bus.Timeout      = r_timeout;
  assign bus.bad_digit    = r_bad_digit;
  assign bus.secs_left    = w_tmr_count;
  assign bus.state_code   = r_state;

endmodule
